// File: rtl/button_debouncer.sv
// button_debouncer: synchronises a raw push-button level and filters contact
// bounce with a counter-based FSM. It produces a clean level plus one-cycle
// rise and fall strobes.
// Optional long-press flag: define BUTTON_DEBOUNCER_LONG_PRESS_EN to build it.
// Otherwise output_long_press is tied to 0.
module button_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_WIDTH       = 5,
    parameter int unsigned HOLD_CYCLES     = 64,
    parameter int unsigned HOLD_WIDTH      = 8
) (
    input  logic input_clock1_clk_1,
    input  logic input_input_switch3__preset_3,
    input  logic input_push_button2_raw,
    output logic output_debounced,
    output logic output_rise_pulse,
    output logic output_fall_pulse,
    output logic output_long_press
);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] WAIT_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] WAIT_LOW  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES);

    // Reject illegal parameterisations at elaboration time.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        DEBOUNCE_CYCLES >= (32'd1 << CNT_WIDTH) ||
        HOLD_CYCLES < 1 || HOLD_CYCLES >= (32'd1 << HOLD_WIDTH)) begin : g_bad_param
        $error("button_debouncer: illegal parameter value");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   sync_bit;

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], input_push_button2_raw};
    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Synchroniser chain, FSM state, counter and registered outputs.
    always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch3__preset_3) begin
        if (!input_input_switch3__preset_3) begin
            sync_q  <= '0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Debounce FSM: a new level must persist DEBOUNCE_CYCLES edges to commit.
    always_comb begin
        logic stable;
        logic differs;
        logic commit;
        logic [CNT_WIDTH-1:0] cnt_inc;

        state_d = state_q;
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        stable  = (state_q == IDLE_HIGH) || (state_q == WAIT_LOW);
        differs = (sync_bit != stable);
        commit  = 1'b0;
        cnt_inc = cnt_q + CNT_ONE;

        case (state_q)
            IDLE_LOW, IDLE_HIGH: begin
                if (differs) begin
                    if (DEBOUNCE_CYCLES == 32'd1) begin
                        commit = 1'b1;
                    end else begin
                        state_d = (state_q == IDLE_LOW) ? WAIT_HIGH : WAIT_LOW;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            default: begin
                if (differs) begin
                    if (cnt_inc == CNT_LAST) begin
                        commit = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end else begin
                    // Bounced back before the count completed: drop the candidate.
                    state_d = (state_q == WAIT_HIGH) ? IDLE_LOW : IDLE_HIGH;
                end
            end
        endcase

        if (commit) begin
            state_d = stable ? IDLE_LOW : IDLE_HIGH;
            cnt_d   = '0;
            level_d = ~stable;
            rise_d  = ~stable;
            fall_d  = stable;
        end
    end

    assign output_debounced  = level_q;
    assign output_rise_pulse = rise_q;
    assign output_fall_pulse = fall_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(HOLD_CYCLES);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);

    logic [HOLD_WIDTH-1:0] hold_q, hold_d;
    logic                  long_q, long_d;

    // Hold counter and long-press flag registers.
    always_ff @(posedge input_clock1_clk_1 or negedge input_input_switch3__preset_3) begin
        if (!input_input_switch3__preset_3) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    // Count stable-high edges, saturating; the fall commit clears everything.
    always_comb begin
        hold_d = hold_q;
        long_d = long_q;
        if (fall_d) begin
            hold_d = '0;
            long_d = 1'b0;
        end else if (level_q) begin
            if (hold_q != HOLD_LAST) begin
                hold_d = hold_q + HOLD_ONE;
            end
            long_d = (hold_d == HOLD_LAST);
        end
    end

    assign output_long_press = long_q;
`else
    assign output_long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (default parameters).
module tb_button_debouncer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic raw   = 1'b0;
    logic deb, rise, fall, lp;

    always #5 clk = ~clk;

    button_debouncer dut (
        .input_clock1_clk_1            (clk),
        .input_input_switch3__preset_3 (rst_n),
        .input_push_button2_raw        (raw),
        .output_debounced              (deb),
        .output_rise_pulse             (rise),
        .output_fall_pulse             (fall),
        .output_long_press             (lp)
    );

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LP_ON = 1'b1;
`else
    localparam bit LP_ON = 1'b0;
`endif

    typedef struct {
        int high_len;
        bit commit;
    } vec_t;

    typedef struct {
        bit is_rise;
        int edge_n;
    } ev_t;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  edge_n   = 0;
    bit  exp_lvl  = 1'b0;
    int  lp_rise  = -1;
    int  lp_fall  = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_n, act, req);
        end
    endtask

    task automatic push_ev(input bit is_rise, input int at_edge);
        ev_t e;
        e.is_rise = is_rise;
        e.edge_n  = at_edge;
        exp_q.push_back(e);
    endtask

    // Advance one edge and compare outputs against the expected schedule.
    task automatic tick();
        ev_t e;
        bit  lp_exp;
        @(posedge clk);
        edge_n++;
        #1;
        if (exp_q.size() != 0 && exp_q[0].edge_n == edge_n) begin
            e = exp_q.pop_front();
            check("rise_pulse", rise, e.is_rise);
            check("fall_pulse", fall, !e.is_rise);
            exp_lvl = e.is_rise;
        end else begin
            check("rise_idle", rise, 0);
            check("fall_idle", fall, 0);
        end
        check("debounced", deb, exp_lvl);
        lp_exp = LP_ON && lp_rise >= 0 && edge_n >= lp_rise && (lp_fall < 0 || edge_n < lp_fall);
        check("long_press", lp, lp_exp);
    endtask

    task automatic run_vec(input vec_t v);
        check("queue_empty_start", exp_q.size(), 0);
        edge_n = 0;
        raw    = 1'b1;
        if (v.commit) begin
            push_ev(1'b1, 18);
            push_ev(1'b0, v.high_len + 18);
            if (v.high_len + 18 > 82) begin
                lp_rise = 82;
                lp_fall = v.high_len + 18;
            end
        end
        repeat (v.high_len) tick();
        raw = 1'b0;
        repeat (40) tick();
        lp_rise = -1;
        lp_fall = -1;
        check("queue_empty_end", exp_q.size(), 0);
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{1,   1'b0};
        vecs[1] = '{5,   1'b0};
        vecs[2] = '{15,  1'b0};
        vecs[3] = '{16,  1'b1};
        vecs[4] = '{20,  1'b1};
        vecs[5] = '{40,  1'b1};
        vecs[6] = '{100, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset_debounced", deb, 0);
        check("reset_rise", rise, 0);
        check("reset_fall", fall, 0);
        check("reset_long", lp, 0);
        rst_n  = 1'b1;
        edge_n = 0;
        repeat (5) tick();

        // Pulse-length table: short pulses filtered, >=16 edges committed.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Bounce: 5 high / 3 low, four times, then steady high.
        edge_n = 0;
        for (int i = 0; i < 4; i++) begin
            raw = 1'b1;
            repeat (5) tick();
            raw = 1'b0;
            repeat (3) tick();
        end
        raw = 1'b1;
        push_ev(1'b1, edge_n + 18);
        repeat (40) tick();
        raw = 1'b0;
        push_ev(1'b0, edge_n + 18);
        repeat (40) tick();
        check("bounce_queue_empty", exp_q.size(), 0);

        // Asynchronous reset while committed high, raw held high.
        edge_n = 0;
        raw    = 1'b1;
        push_ev(1'b1, 18);
        repeat (25) tick();
        check("pre_reset_level", deb, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_debounced", deb, 0);
        check("async_rst_rise", rise, 0);
        check("async_rst_fall", fall, 0);
        check("async_rst_long", lp, 0);
        exp_lvl = 1'b0;
        raw     = 1'b0;
        tick();
        rst_n  = 1'b1;
        edge_n = 0;
        repeat (50) tick();
        check("idle_queue_empty", exp_q.size(), 0);

        // Reset mid-WAIT discards the pending rise; re-debounce after release.
        edge_n = 0;
        raw    = 1'b1;
        repeat (10) tick();
        rst_n   = 1'b0;
        exp_lvl = 1'b0;
        tick();
        rst_n  = 1'b1;
        edge_n = 0;
        push_ev(1'b1, 18);
        repeat (30) tick();
        raw = 1'b0;
        push_ev(1'b0, edge_n + 18);
        repeat (40) tick();
        check("midwait_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Conditions a raw push-button level before it drives the D input of the edge-triggered D flip-flop stage; sits directly upstream of that stage.
- Synchronises the asynchronous button into the clock domain, then filters contact bounce with a counter-based FSM.
- Emits a clean level plus one-cycle rise/fall strobes.
- The debounced level connects straight to the flip-flop D pin.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive stable clock edges required to commit a new level; legal range 1 .. 2^CNT_WIDTH-1.
- CNT_WIDTH, 5, bit width of the bounce counter.
- HOLD_CYCLES, 64, edges of stable high before the long-press flag asserts (optional feature only); legal range 1 .. 2^HOLD_WIDTH-1.
- HOLD_WIDTH, 8, bit width of the hold counter (optional feature only).

Ports:
- input_clock1_clk_1  input  1  system clock; all state updates on the rising edge.
- input_input_switch3__preset_3  input  1  reset, asynchronous, active-low.
- input_push_button2_raw  input  1  raw, bouncy, asynchronous button level.
- output_debounced  output  1  filtered button level; feeds the flip-flop D input.
- output_rise_pulse  output  1  one-cycle strobe on a committed 0->1 transition.
- output_fall_pulse  output  1  one-cycle strobe on a committed 1->0 transition.
- output_long_press  output  1  high while the button has been held (optional feature).

Behaviour:
- Reset (input_input_switch3__preset_3 = 0) takes effect immediately, with no clock required:
  - all synchroniser flops = 0, counter = 0, FSM = IDLE_LOW;
  - all outputs = 0;
  - reset has priority over everything.
- Reset release is synchronous in effect: the first functional edge is the first rising clock edge with reset = 1.
- Synchroniser: an SYNC_STAGES-deep shift chain of raw input; sync_q is the last stage. Only sync_q feeds the FSM.
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. Let stable = 1 in the *_HIGH states.
- IDLE_x with sync_q == stable: stay; cnt = 0.
- IDLE_x with sync_q != stable:
  - if DEBOUNCE_CYCLES == 1, commit immediately;
  - otherwise go to WAIT_y with cnt = 1.
- WAIT_y with sync_q != stable:
  - cnt+1 == DEBOUNCE_CYCLES: commit;
  - else cnt = cnt+1.
- WAIT_y with sync_q == stable (bounce back): abort to IDLE_x, cnt = 0, no output change.
- Commit: toggle output_debounced, enter the opposite IDLE state, cnt = 0, and on the same edge set:
  - output_rise_pulse = 1 for a 0->1 commit, or
  - output_fall_pulse = 1 for a 1->0 commit.
- Strobes are registered and high for exactly one cycle; they self-clear on the next edge. Rise and fall are never high together.
- Latency: raw changes between edge 0 and edge 1 and then holds. output_debounced changes after edge SYNC_STAGES + DEBOUNCE_CYCLES (18 with defaults).
- A glitch shorter than DEBOUNCE_CYCLES at sync_q never reaches the output. The counter never wraps, because it always commits or aborts first.
- Reset asserted mid-WAIT discards the pending transition. After release the block re-debounces from IDLE_LOW, even if the button is still held.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_LONG_PRESS_EN.
- Enabled:
  - a HOLD_WIDTH hold counter increments on every edge while output_debounced = 1, saturating at HOLD_CYCLES;
  - output_long_press = 1 once the count reaches HOLD_CYCLES, and stays high until the fall commit;
  - on the fall commit, the counter and output_long_press clear on the same edge;
  - reset clears both.
- Disabled: the port remains present but is tied to 0, no hold counter is instantiated, and HOLD_* parameters are ignored.

Test Plan:
- Reset/idle: assert reset with raw = 1 mid-run -> all outputs 0 immediately (before the next clock edge). Release with raw = 0 -> outputs stay 0 for 50 cycles.
- Clean press: raw 0->1 between edges 0 and 1 -> output_debounced = 1 after edge 18, output_rise_pulse high only during cycle 18->19. Release -> output_fall_pulse exactly one cycle, 18 edges later.
- Bounce rejection: raw toggles high 5 cycles / low 3 cycles, four times, then stays high -> no pulse during bouncing; single rise commit 18 edges after the final low->high.
- Boundary: a raw high pulse holding sync_q high for 15 edges -> no commit. Holding it for 16 edges -> commit.
- Reset mid-WAIT: raw high for 10 edges, pulse reset low for 1 cycle, raw stays high -> no pulse before reset; commit 18 edges after reset release.
- Long press (macro on): hold raw high -> output_long_press rises 64 edges after the rise commit. Release -> it clears on the same edge output_fall_pulse rises. With the macro off, output_long_press stays 0 throughout.
